// File: rtl/atm_pkg.sv
// Shared types for the ATM session controller: session states, operation
// codes and the keypad BCD digit type.
package atm_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        PIN,
        CHECK,
        MENU,
        EXEC,
        DONE,
        EJECT,
        RETAIN
    } state_e;

    typedef enum logic [1:0] {
        OP_QUERY    = 2'b00,
        OP_WITHDRAW = 2'b01,
        OP_DEPOSIT  = 2'b10,
        OP_CANCEL   = 2'b11
    } op_e;

    typedef logic [3:0] bcd_t;

    localparam int PIN_DIGITS = 4;

endpackage

// File: rtl/atm_pin_collector.sv
// Keypad PIN collector: shifts BCD digits in from the LSB end, counts them and
// flags the strobe that delivers the final digit. Clear empties it.
module atm_pin_collector
    import atm_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    digit_valid,
    input  bcd_t                    digit,
    output logic [4*PIN_DIGITS-1:0] pin_value,
    output logic                    full
);

    localparam int CNT_W = $clog2(PIN_DIGITS + 1);

    logic [4*PIN_DIGITS-1:0] pin_q, pin_d;
    logic [CNT_W-1:0]        count_q, count_d;

    // Accept digits until the PIN is complete; clear has priority over a strobe.
    always_comb begin
        pin_d   = pin_q;
        count_d = count_q;
        if (clear) begin
            pin_d   = '0;
            count_d = '0;
        end else if (digit_valid && (count_q != CNT_W'(PIN_DIGITS))) begin
            pin_d   = {pin_q[4*PIN_DIGITS-5:0], digit};
            count_d = count_q + 1'b1;
        end
    end

    // Digit register and counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pin_q   <= '0;
            count_q <= '0;
        end else begin
            pin_q   <= pin_d;
            count_q <= count_d;
        end
    end

    assign pin_value = pin_q;
    assign full      = !clear && digit_valid && (count_q == CNT_W'(PIN_DIGITS - 1));

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session controller: card detect, PIN collection and check with retry
// limit, one balance operation with write-back, eject/retain and idle timeout.
// Optional feature macro ATM_SESSION_LIMIT_EN adds a per-session withdrawal cap.
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int CARD_WIDTH     = 6,
    parameter int PASS_WIDTH     = 16,
    parameter int BLNC_WIDTH     = 20,
    parameter int MAX_TRIES      = 3,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int SESSION_LIMIT  = 100000
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  card_in,
    input  logic [CARD_WIDTH-1:0] card_no,
    input  logic                  pass_flag,
    input  logic [PASS_WIDTH-1:0] password,
    input  logic [BLNC_WIDTH-1:0] balance,
    input  logic [3:0]            digit,
    input  logic                  digit_valid,
    input  logic [1:0]            op_sel,
    input  logic                  op_valid,
    input  logic [BLNC_WIDTH-1:0] amount,
    output logic                  operation_done,
    output logic [BLNC_WIDTH-1:0] update_balance,
    output logic                  eject,
    output logic                  card_retained,
    output logic                  pin_error,
    output logic                  insufficient,
    output logic                  busy
);

    localparam int TRY_W   = $clog2(MAX_TRIES + 1);
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e                  state_q, state_d;
    logic                    card_prev_q, card_prev_d;
    logic [TRY_W-1:0]        tries_q, tries_d;
    logic [TIMER_W-1:0]      timer_q, timer_d;
    logic [BLNC_WIDTH-1:0]   shadow_q, shadow_d;
    op_e                     op_q, op_d;
    logic [BLNC_WIDTH-1:0]   amount_q, amount_d;
    logic [BLNC_WIDTH-1:0]   update_q, update_d;

    logic [4*PIN_DIGITS-1:0] pin_value;
    logic                    pin_full;
    logic                    pin_clear;
    logic                    pin_match;
    logic                    tries_last;
    logic                    any_strobe;
    logic                    timer_expired;
    logic [BLNC_WIDTH:0]     deposit_sum;
    logic                    over_limit;
    logic                    withdraw_refused;
    logic [BLNC_WIDTH-1:0]   exec_result;
    logic                    unused_ok;

    assign pin_clear = (state_q != PIN);

    atm_pin_collector u_pin (
        .clk         (clk),
        .reset       (reset),
        .clear       (pin_clear),
        .digit_valid (digit_valid),
        .digit       (digit),
        .pin_value   (pin_value),
        .full        (pin_full)
    );

    assign pin_match     = (PASS_WIDTH'(pin_value) == password);
    assign tries_last    = (tries_q == TRY_W'(MAX_TRIES - 1));
    assign any_strobe    = digit_valid || op_valid;
    assign timer_expired = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) && !any_strobe;

    assign deposit_sum      = {1'b0, shadow_q} + {1'b0, amount_q};
    assign withdraw_refused = (op_q == OP_WITHDRAW) && ((amount_q > shadow_q) || over_limit);

`ifdef ATM_SESSION_LIMIT_EN
    logic [BLNC_WIDTH:0]   accum_q, accum_d;
    logic [BLNC_WIDTH+1:0] accum_sum;

    assign accum_sum  = {1'b0, accum_q} + {2'b0, amount_q};
    assign over_limit = (accum_sum > (BLNC_WIDTH + 2)'(SESSION_LIMIT));
    assign unused_ok  = ^card_no;

    // Session withdrawal total: restarts every session, grows on accepted withdraws.
    always_comb begin
        accum_d = accum_q;
        if (state_q == IDLE) begin
            accum_d = '0;
        end else if ((state_q == EXEC) && (op_q == OP_WITHDRAW) && !withdraw_refused) begin
            accum_d = accum_sum[BLNC_WIDTH:0];
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (reset) accum_q <= '0;
        else       accum_q <= accum_d;
    end
`else
    assign over_limit = 1'b0;
    assign unused_ok  = ^{card_no, (SESSION_LIMIT < 0)};
`endif

    // Result of the latched operation, applied against the shadow balance.
    always_comb begin
        exec_result = shadow_q;
        case (op_q)
            OP_WITHDRAW: exec_result = withdraw_refused ? shadow_q : (shadow_q - amount_q);
            OP_DEPOSIT:  exec_result = deposit_sum[BLNC_WIDTH] ? '1 : deposit_sum[BLNC_WIDTH-1:0];
            default:     exec_result = shadow_q;
        endcase
    end

    // State register plus session datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            card_prev_q <= 1'b0;
            tries_q     <= '0;
            timer_q     <= '0;
            shadow_q    <= '0;
            op_q        <= OP_QUERY;
            amount_q    <= '0;
            update_q    <= '0;
        end else begin
            state_q     <= state_d;
            card_prev_q <= card_prev_d;
            tries_q     <= tries_d;
            timer_q     <= timer_d;
            shadow_q    <= shadow_d;
            op_q        <= op_d;
            amount_q    <= amount_d;
            update_q    <= update_d;
        end
    end

    // Next-state sequencing; card removal in PIN/MENU beats every other event.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (card_in && !card_prev_q) state_d = LOAD;
            LOAD:   state_d = pass_flag ? PIN : EJECT;
            PIN: begin
                if (!card_in)           state_d = IDLE;
                else if (pin_full)      state_d = CHECK;
                else if (timer_expired) state_d = EJECT;
            end
            CHECK: begin
                if (pin_match)       state_d = MENU;
                else if (tries_last) state_d = RETAIN;
                else                 state_d = PIN;
            end
            MENU: begin
                if (!card_in)           state_d = IDLE;
                else if (op_valid)      state_d = (op_e'(op_sel) == OP_CANCEL) ? EJECT : EXEC;
                else if (timer_expired) state_d = EJECT;
            end
            EXEC:    state_d = DONE;
            DONE:    state_d = EJECT;
            EJECT:   state_d = IDLE;
            RETAIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates: shadow load, op latch, retry count and idle timer.
    always_comb begin
        card_prev_d = card_in;
        tries_d     = tries_q;
        shadow_d    = shadow_q;
        op_d        = op_q;
        amount_d    = amount_q;
        update_d    = update_q;
        timer_d     = '0;
        if (((state_q == PIN) || (state_q == MENU)) && (state_d == state_q) && !any_strobe) begin
            timer_d = timer_q + 1'b1;
        end
        case (state_q)
            IDLE:  tries_d = '0;
            LOAD:  shadow_d = balance;
            CHECK: if (!pin_match) tries_d = tries_q + 1'b1;
            MENU: begin
                if (op_valid) begin
                    op_d     = op_e'(op_sel);
                    amount_d = amount;
                end
            end
            EXEC:  update_d = exec_result;
            DONE:  shadow_d = update_q;
            default: ;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        operation_done = (state_q == DONE);
        update_balance = (state_q == DONE) ? update_q : '0;
        eject          = (state_q == EJECT);
        card_retained  = (state_q == RETAIN);
        pin_error      = (state_q == CHECK) && !pin_match;
        insufficient   = (state_q == EXEC) && withdraw_refused;
        busy           = (state_q != IDLE);
    end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Self-checking bench for atm_session_ctrl: directed scenarios plus random
// sessions scored against a behavioural model of one banking operation.
module tb_atm_session_ctrl;

    localparam int     CARD_WIDTH     = 6;
    localparam int     PASS_WIDTH     = 16;
    localparam int     BLNC_WIDTH     = 20;
    localparam int     MAX_TRIES      = 3;
    localparam int     TIMEOUT_CYCLES = 1000;
    localparam int     SESSION_LIMIT  = 100000;
    localparam longint BLNC_MAX       = (64'd1 << BLNC_WIDTH) - 1;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  card_in = 1'b0;
    logic [CARD_WIDTH-1:0] card_no = '0;
    logic                  pass_flag = 1'b0;
    logic [PASS_WIDTH-1:0] password = '0;
    logic [BLNC_WIDTH-1:0] balance = '0;
    logic [3:0]            digit = '0;
    logic                  digit_valid = 1'b0;
    logic [1:0]            op_sel = '0;
    logic                  op_valid = 1'b0;
    logic [BLNC_WIDTH-1:0] amount = '0;
    logic                  operation_done;
    logic [BLNC_WIDTH-1:0] update_balance;
    logic                  eject;
    logic                  card_retained;
    logic                  pin_error;
    logic                  insufficient;
    logic                  busy;

    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     n_done, n_eject, n_retain, n_pinerr, n_insuf;
    int     done_cyc, eject_cyc, busy_cyc;
    int     card_cyc, op_cyc, last_digit_cyc;
    longint last_update;

    atm_session_ctrl #(
        .CARD_WIDTH     (CARD_WIDTH),
        .PASS_WIDTH     (PASS_WIDTH),
        .BLNC_WIDTH     (BLNC_WIDTH),
        .MAX_TRIES      (MAX_TRIES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SESSION_LIMIT  (SESSION_LIMIT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .card_in        (card_in),
        .card_no        (card_no),
        .pass_flag      (pass_flag),
        .password       (password),
        .balance        (balance),
        .digit          (digit),
        .digit_valid    (digit_valid),
        .op_sel         (op_sel),
        .op_valid       (op_valid),
        .amount         (amount),
        .operation_done (operation_done),
        .update_balance (update_balance),
        .eject          (eject),
        .card_retained  (card_retained),
        .pin_error      (pin_error),
        .insufficient   (insufficient),
        .busy           (busy)
    );

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Observe output pulses mid-cycle, recording counts and when they occurred.
    always @(negedge clk) begin
        if (operation_done) begin
            n_done++;
            done_cyc    = cyc;
            last_update = longint'(update_balance);
        end
        if (eject) begin
            n_eject++;
            eject_cyc = cyc;
        end
        if (card_retained) n_retain++;
        if (pin_error) n_pinerr++;
        if (insufficient) n_insuf++;
        if (busy && (busy_cyc < 0)) busy_cyc = cyc;
    end

    // Expected result of a single operation in a fresh session.
    function automatic longint model_update(input int op, input longint bal, input longint amt,
                                            output bit refused);
        refused = 1'b0;
        case (op)
            1: begin
                if (amt > bal) refused = 1'b1;
`ifdef ATM_SESSION_LIMIT_EN
                if (amt > SESSION_LIMIT) refused = 1'b1;
`endif
                return refused ? bal : (bal - amt);
            end
            2:       return ((bal + amt) > BLNC_MAX) ? BLNC_MAX : (bal + amt);
            default: return bal;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        n_done = 0; n_eject = 0; n_retain = 0; n_pinerr = 0; n_insuf = 0;
        done_cyc = -1; eject_cyc = -1; busy_cyc = -1; last_update = -1;
    endtask

    task automatic insert_card(input logic [5:0] card, input logic pf, input logic [15:0] pw,
                               input logic [19:0] bal);
        card_no   = card;
        pass_flag = pf;
        password  = pw;
        balance   = bal;
        clear_obs();
        card_in  = 1'b1;
        card_cyc = cyc;
        tick();
        tick();
    endtask

    task automatic enter_pin(input logic [15:0] pin);
        for (int i = 3; i >= 0; i--) begin
            digit          = pin[i*4 +: 4];
            digit_valid    = 1'b1;
            last_digit_cyc = cyc;
            tick();
        end
        digit_valid = 1'b0;
        tick();
    endtask

    task automatic do_op(input logic [1:0] op, input logic [19:0] amt);
        op_sel   = op;
        amount   = amt;
        op_valid = 1'b1;
        op_cyc   = cyc;
        tick();
        op_valid = 1'b0;
        repeat (4) tick();
    endtask

    task automatic remove_card();
        card_in = 1'b0;
        repeat (2) tick();
    endtask

    task automatic session(input logic [5:0] card, input logic [15:0] pw, input logic [19:0] bal,
                           input int wrong, input logic [1:0] op, input logic [19:0] amt);
        insert_card(card, 1'b1, pw, bal);
        for (int w = 0; w < wrong; w++) enter_pin(pw + 16'h1);
        enter_pin(pw);
        do_op(op, amt);
        remove_card();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        total += 7;
        if (operation_done !== 1'b0) begin bad++; $display("[TB] FAIL reset.operation_done got=%b want=0", operation_done); end
        if (update_balance !== '0) begin bad++; $display("[TB] FAIL reset.update_balance got=%0d want=0", update_balance); end
        if (eject !== 1'b0) begin bad++; $display("[TB] FAIL reset.eject got=%b want=0", eject); end
        if (card_retained !== 1'b0) begin bad++; $display("[TB] FAIL reset.card_retained got=%b want=0", card_retained); end
        if (pin_error !== 1'b0) begin bad++; $display("[TB] FAIL reset.pin_error got=%b want=0", pin_error); end
        if (insufficient !== 1'b0) begin bad++; $display("[TB] FAIL reset.insufficient got=%b want=0", insufficient); end
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset.busy got=%b want=0", busy); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_withdraw();
        longint exp;
        bit     ref_flag;
        session(6'd1, 16'h3506, 20'd50000, 0, 2'b01, 20'd20000);
        exp = model_update(1, 50000, 20000, ref_flag);
        total += 7;
        if (n_done !== 1) begin bad++; $display("[TB] FAIL withdraw.done_count got=%0d want=1", n_done); end
        if (last_update !== exp) begin bad++; $display("[TB] FAIL withdraw.update got=%0d want=%0d", last_update, exp); end
        if (n_insuf !== 0) begin bad++; $display("[TB] FAIL withdraw.insufficient got=%0d want=0", n_insuf); end
        if (n_eject !== 1) begin bad++; $display("[TB] FAIL withdraw.eject_count got=%0d want=1", n_eject); end
        if (done_cyc - op_cyc !== 2) begin bad++; $display("[TB] FAIL withdraw.op_latency got=%0d want=2", done_cyc - op_cyc); end
        if (busy_cyc - card_cyc !== 1) begin bad++; $display("[TB] FAIL withdraw.busy_latency got=%0d want=1", busy_cyc - card_cyc); end
        if (eject_cyc - done_cyc !== 1) begin bad++; $display("[TB] FAIL withdraw.eject_after_done got=%0d want=1", eject_cyc - done_cyc); end
    endtask

    task automatic test_insufficient();
        session(6'd9, 16'h1470, 20'd1, 0, 2'b01, 20'd2);
        total += 4;
        if (n_insuf !== 1) begin bad++; $display("[TB] FAIL insuf.pulse got=%0d want=1", n_insuf); end
        if (n_done !== 1) begin bad++; $display("[TB] FAIL insuf.done_count got=%0d want=1", n_done); end
        if (last_update !== 64'd1) begin bad++; $display("[TB] FAIL insuf.update got=%0d want=1", last_update); end
        if (n_eject !== 1) begin bad++; $display("[TB] FAIL insuf.eject_count got=%0d want=1", n_eject); end
    endtask

    task automatic test_retain();
        insert_card(6'd0, 1'b1, 16'h1234, 20'd1000);
        for (int t = 0; t < MAX_TRIES; t++) enter_pin(16'h9999);
        repeat (3) tick();
        remove_card();
        total += 4;
        if (n_pinerr !== MAX_TRIES) begin bad++; $display("[TB] FAIL retain.pin_errors got=%0d want=%0d", n_pinerr, MAX_TRIES); end
        if (n_retain !== 1) begin bad++; $display("[TB] FAIL retain.retained got=%0d want=1", n_retain); end
        if (n_done !== 0) begin bad++; $display("[TB] FAIL retain.done_count got=%0d want=0", n_done); end
        if (n_eject !== 0) begin bad++; $display("[TB] FAIL retain.eject_count got=%0d want=0", n_eject); end
    endtask

    task automatic test_deposit_saturate();
        session(6'd3, 16'h0042, 20'd200000, 0, 2'b10, 20'd900000);
        total += 3;
        if (n_done !== 1) begin bad++; $display("[TB] FAIL deposit.done_count got=%0d want=1", n_done); end
        if (last_update !== BLNC_MAX) begin bad++; $display("[TB] FAIL deposit.update got=%0d want=%0d", last_update, BLNC_MAX); end
        if (n_insuf !== 0) begin bad++; $display("[TB] FAIL deposit.insufficient got=%0d want=0", n_insuf); end
    endtask

    task automatic test_no_pass();
        insert_card(6'd5, 1'b0, 16'h1111, 20'd10);
        repeat (3) tick();
        remove_card();
        total += 3;
        if (eject_cyc - card_cyc !== 2) begin bad++; $display("[TB] FAIL nopass.eject_latency got=%0d want=2", eject_cyc - card_cyc); end
        if (n_eject !== 1) begin bad++; $display("[TB] FAIL nopass.eject_count got=%0d want=1", n_eject); end
        if (n_done !== 0) begin bad++; $display("[TB] FAIL nopass.done_count got=%0d want=0", n_done); end
    endtask

    task automatic test_timeout();
        int exp_cyc;
        insert_card(6'd7, 1'b1, 16'h2580, 20'd300);
        enter_pin(16'h2580);
        repeat (TIMEOUT_CYCLES + 5) tick();
        exp_cyc = last_digit_cyc + 2 + TIMEOUT_CYCLES;
        remove_card();
        total += 3;
        if (eject_cyc !== exp_cyc) begin bad++; $display("[TB] FAIL timeout.eject_cycle got=%0d want=%0d", eject_cyc, exp_cyc); end
        if (n_eject !== 1) begin bad++; $display("[TB] FAIL timeout.eject_count got=%0d want=1", n_eject); end
        if (n_done !== 0) begin bad++; $display("[TB] FAIL timeout.done_count got=%0d want=0", n_done); end
    endtask

    task automatic test_card_pull();
        insert_card(6'd11, 1'b1, 16'h4321, 20'd77);
        digit = 4'd4; digit_valid = 1'b1; tick();
        digit = 4'd3; tick();
        digit_valid = 1'b0;
        card_in = 1'b0;
        tick();
        total += 4;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL pull.busy got=%b want=0", busy); end
        repeat (3) tick();
        if (n_eject !== 0) begin bad++; $display("[TB] FAIL pull.eject_count got=%0d want=0", n_eject); end
        if (n_pinerr !== 0) begin bad++; $display("[TB] FAIL pull.pin_errors got=%0d want=0", n_pinerr); end
        if (n_done !== 0) begin bad++; $display("[TB] FAIL pull.done_count got=%0d want=0", n_done); end
    endtask

    task automatic test_reset_in_exec();
        insert_card(6'd2, 1'b1, 16'h8642, 20'd5000);
        enter_pin(16'h8642);
        op_sel = 2'b01; amount = 20'd100; op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        reset = 1'b1;
        card_in = 1'b0;
        tick();
        total += 5;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rstexec.busy got=%b want=0", busy); end
        if (operation_done !== 1'b0) begin bad++; $display("[TB] FAIL rstexec.operation_done got=%b want=0", operation_done); end
        if (update_balance !== '0) begin bad++; $display("[TB] FAIL rstexec.update_balance got=%0d want=0", update_balance); end
        if (eject !== 1'b0) begin bad++; $display("[TB] FAIL rstexec.eject got=%b want=0", eject); end
        reset = 1'b0;
        repeat (4) tick();
        if (n_done !== 0) begin bad++; $display("[TB] FAIL rstexec.done_count got=%0d want=0", n_done); end
    endtask

    task automatic test_limit();
        longint exp;
        bit     ref_flag;
        session(6'd4, 16'h7777, 20'd200000, 0, 2'b01, 20'd150000);
        exp = model_update(1, 200000, 150000, ref_flag);
        total += 2;
        if (n_insuf !== int'(ref_flag)) begin bad++; $display("[TB] FAIL limit.insufficient got=%0d want=%0d", n_insuf, ref_flag); end
        if (last_update !== exp) begin bad++; $display("[TB] FAIL limit.update got=%0d want=%0d", last_update, exp); end
    endtask

    task automatic test_back_to_back();
        op_sel = 2'b10; amount = 20'd5; op_valid = 1'b1; digit_valid = 1'b1;
        tick();
        op_valid = 1'b0; digit_valid = 1'b0;
        session(6'd20, 16'h1357, 20'd1000, 1, 2'b10, 20'd234);
        total += 2;
        if (last_update !== 64'd1234) begin bad++; $display("[TB] FAIL b2b.first_update got=%0d want=1234", last_update); end
        session(6'd21, 16'h2468, 20'd800, 0, 2'b00, 20'd99);
        if (last_update !== 64'd800) begin bad++; $display("[TB] FAIL b2b.second_update got=%0d want=800", last_update); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            logic [15:0] pw;
            logic [19:0] bal, amt;
            int          op, wrong;
            longint      exp;
            bit          ref_flag;
            for (int d = 0; d < 4; d++) pw[d*4 +: 4] = 4'($urandom_range(0, 9));
            bal   = 20'($urandom_range(0, 32'hFFFFF));
            amt   = ($urandom_range(0, 1) == 1) ? 20'($urandom_range(0, 32'hFFFFF)) : 20'($urandom_range(0, 200000));
            op    = $urandom_range(0, 3);
            wrong = $urandom_range(0, MAX_TRIES - 1);
            session(6'($urandom_range(0, 63)), pw, bal, wrong, 2'(op), amt);
            exp = model_update(op, longint'(bal), longint'(amt), ref_flag);
            total += 5;
            if (n_pinerr !== wrong) begin bad++; $display("[TB] FAIL rand%0d.pin_errors got=%0d want=%0d", it, n_pinerr, wrong); end
            if (n_eject !== 1) begin bad++; $display("[TB] FAIL rand%0d.eject_count got=%0d want=1", it, n_eject); end
            if (n_insuf !== int'(ref_flag)) begin bad++; $display("[TB] FAIL rand%0d.insufficient got=%0d want=%0d", it, n_insuf, ref_flag); end
            if (op == 3) begin
                if (n_done !== 0) begin bad++; $display("[TB] FAIL rand%0d.cancel_done got=%0d want=0", it, n_done); end
                if (last_update !== -1) begin bad++; $display("[TB] FAIL rand%0d.cancel_update got=%0d want=none", it, last_update); end
            end else begin
                if (n_done !== 1) begin bad++; $display("[TB] FAIL rand%0d.done_count got=%0d want=1", it, n_done); end
                if (last_update !== exp) begin bad++; $display("[TB] FAIL rand%0d.update got=%0d want=%0d", it, last_update, exp); end
            end
        end
    endtask

    // Scenario sequence and final summary.
    initial begin
        clear_obs();
        test_reset();
        test_withdraw();
        test_insufficient();
        test_retain();
        test_deposit_saturate();
        test_no_pass();
        test_timeout();
        test_card_pull();
        test_reset_in_exec();
        test_limit();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
